// File: rtl/aidc_pkg.sv
// Shared definitions for the AIDC address-channel burst splitter:
// FSM states, AXI burst-type encodings and the sub-burst count helper.
package aidc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'd0;
  localparam logic [1:0] BURST_INCR  = 2'd1;
  localparam logic [1:0] BURST_WRAP  = 2'd2;

  // Number of MAX_LEN-beat sub-bursts needed for alen+1 beats, minus one.
  function automatic logic [7:0] calc_nsub_m1(input logic [7:0] alen, input int unsigned max_len);
    logic [8:0] total;
    total = {1'b0, alen} + 9'd1;
    return 8'((total - 9'd1) >> $clog2(max_len));
  endfunction

endpackage

// File: rtl/aidc_burst_splitter_if.sv
// Core-side request channel and memory-side sub-burst channel of the splitter.
// The slave modport is the splitter's view; master is the surrounding system.
interface aidc_burst_splitter_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4
);

  logic              core_avalid;
  logic              core_aready;
  logic [ID_W-1:0]   core_aid;
  logic [ADDR_W-1:0] core_aaddr;
  logic [7:0]        core_alen;
  logic [2:0]        core_asize;
  logic [1:0]        core_aburst;

  logic              mem_avalid;
  logic              mem_aready;
  logic [ID_W-1:0]   mem_aid;
  logic [ADDR_W-1:0] mem_aaddr;
  logic [7:0]        mem_alen;
  logic [2:0]        mem_asize;
  logic [1:0]        mem_aburst;
  logic              mem_a_last;
  logic [7:0]        mem_a_nsub_m1;

  modport master (
    output core_avalid, core_aid, core_aaddr, core_alen, core_asize, core_aburst,
    input  core_aready,
    input  mem_avalid, mem_aid, mem_aaddr, mem_alen, mem_asize, mem_aburst,
    input  mem_a_last, mem_a_nsub_m1,
    output mem_aready
  );

  modport slave (
    input  core_avalid, core_aid, core_aaddr, core_alen, core_asize, core_aburst,
    output core_aready,
    output mem_avalid, mem_aid, mem_aaddr, mem_alen, mem_asize, mem_aburst,
    output mem_a_last, mem_a_nsub_m1,
    input  mem_aready
  );

endinterface

// File: rtl/aidc_burst_splitter.sv
// Splits INCR/FIXED AXI address bursts longer than MAX_LEN beats into tagged
// sub-bursts; WRAP and short bursts pass through as a single sub-burst.
module aidc_burst_splitter
  import aidc_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ID_W    = 4,
  parameter int MAX_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  aidc_burst_splitter_if.slave bus
);

  localparam logic [8:0] MAX_BEATS = 9'(MAX_LEN);
  localparam logic [7:0] MAX_ALEN  = 8'(MAX_LEN - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              w_core_aready;

  logic              r_mem_avalid;
  logic [ID_W-1:0]   r_mem_aid;
  logic [ADDR_W-1:0] r_mem_aaddr;
  logic [7:0]        r_mem_alen;
  logic [2:0]        r_mem_asize;
  logic [1:0]        r_mem_aburst;
  logic              r_mem_a_last;
  logic [7:0]        r_mem_a_nsub_m1;
  logic [8:0]        r_rem_beats;
  logic [7:0]        r_sub_idx;

  logic              w_accept;
  logic              w_mem_hs;
  logic [8:0]        w_total;
  logic              w_single;
  logic [ADDR_W-1:0] w_addr_step;
  logic [ADDR_W-1:0] w_next_addr;
  logic [7:0]        w_next_alen;
  logic              w_next_last;
  logic [8:0]        w_next_rem;

  assign w_accept    = (r_state == ST_IDLE) && bus.core_avalid;
  assign w_mem_hs    = r_mem_avalid && bus.mem_aready;
  assign w_total     = {1'b0, bus.core_alen} + 9'd1;
  assign w_single    = (bus.core_aburst == BURST_WRAP) || (w_total <= MAX_BEATS);
  assign w_addr_step = ADDR_W'(MAX_LEN) << r_mem_asize;
  assign w_next_addr = (r_mem_aburst == BURST_INCR) ? (r_mem_aaddr + w_addr_step) : r_mem_aaddr;
  // r_rem_beats counts beats still to be issued after the sub-burst on the bus.
  assign w_next_alen = (r_rem_beats > MAX_BEATS) ? MAX_ALEN : 8'(r_rem_beats - 9'd1);
  assign w_next_rem  = (r_rem_beats > MAX_BEATS) ? (r_rem_beats - MAX_BEATS) : 9'd0;
  assign w_next_last = ((r_sub_idx + 8'd1) == r_mem_a_nsub_m1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.core_avalid) begin
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (w_mem_hs && r_mem_a_last) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_core_aready = 1'b0;
    case (r_state)
      ST_IDLE:  w_core_aready = 1'b1;
      ST_ISSUE: w_core_aready = 1'b0;
      default:  w_core_aready = 1'b0;
    endcase
  end

  // Sub-burst datapath: load on core accept, advance on each non-final mem handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_avalid    <= 1'b0;
      r_mem_aid       <= '0;
      r_mem_aaddr     <= '0;
      r_mem_alen      <= 8'd0;
      r_mem_asize     <= 3'd0;
      r_mem_aburst    <= 2'd0;
      r_mem_a_last    <= 1'b0;
      r_mem_a_nsub_m1 <= 8'd0;
      r_rem_beats     <= 9'd0;
      r_sub_idx       <= 8'd0;
    end else if (w_accept) begin
      r_mem_avalid <= 1'b1;
      r_mem_aid    <= bus.core_aid;
      r_mem_aaddr  <= bus.core_aaddr;
      r_mem_asize  <= bus.core_asize;
      r_mem_aburst <= bus.core_aburst;
      r_sub_idx    <= 8'd0;
      if (w_single) begin
        r_mem_alen      <= bus.core_alen;
        r_mem_a_last    <= 1'b1;
        r_mem_a_nsub_m1 <= 8'd0;
        r_rem_beats     <= 9'd0;
      end else begin
        r_mem_alen      <= MAX_ALEN;
        r_mem_a_last    <= 1'b0;
        r_mem_a_nsub_m1 <= calc_nsub_m1(bus.core_alen, MAX_LEN);
        r_rem_beats     <= w_total - MAX_BEATS;
      end
    end else if (w_mem_hs) begin
      if (r_mem_a_last) begin
        r_mem_avalid <= 1'b0;
      end else begin
        r_mem_aaddr  <= w_next_addr;
        r_mem_alen   <= w_next_alen;
        r_mem_a_last <= w_next_last;
        r_rem_beats  <= w_next_rem;
        r_sub_idx    <= r_sub_idx + 8'd1;
      end
    end else begin
      r_mem_avalid <= r_mem_avalid;
    end
  end

  assign bus.core_aready   = w_core_aready;
  assign bus.mem_avalid    = r_mem_avalid;
  assign bus.mem_aid       = r_mem_aid;
  assign bus.mem_aaddr     = r_mem_aaddr;
  assign bus.mem_alen      = r_mem_alen;
  assign bus.mem_asize     = r_mem_asize;
  assign bus.mem_aburst    = r_mem_aburst;
  assign bus.mem_a_last    = r_mem_a_last;
  assign bus.mem_a_nsub_m1 = r_mem_a_nsub_m1;

endmodule
